// File: rtl/controle_verificacao_if.sv
// Password packet type and the entry/verifier bus of the lock sequencer.
// slave is the sequencer's view; master is the keypad/verifier side.
package controle_verificacao_pkg;
  typedef logic [15:0] senhaPac_t;
endpackage

interface controle_verificacao_if #(
  parameter int NUM_SLOTS = 4
);
  import controle_verificacao_pkg::*;

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic                          senha_valid;
  senhaPac_t                     senha_in;
  senhaPac_t [NUM_SLOTS-1:0]     senhas_cad;
  logic      [NUM_SLOTS-1:0]     slot_ativo;
  logic                          vs_clr;
  logic                          vs_valid_in;
  senhaPac_t                     vs_senha_teste;
  senhaPac_t                     vs_senha_real;
  logic                          vs_senha_ok;
  logic                          vs_done;
  logic                          busy;
  logic                          acesso_ok;
  logic                          acesso_negado;
  logic      [IDX_W-1:0]         slot_match;
  logic                          bloqueado;
  logic      [3:0]               tentativas;

  modport slave (
    input  senha_valid, senha_in, senhas_cad, slot_ativo, vs_senha_ok, vs_done,
    output vs_clr, vs_valid_in, vs_senha_teste, vs_senha_real,
    output busy, acesso_ok, acesso_negado, slot_match, bloqueado, tentativas
  );

  modport master (
    output senha_valid, senha_in, senhas_cad, slot_ativo, vs_senha_ok, vs_done,
    input  vs_clr, vs_valid_in, vs_senha_teste, vs_senha_real,
    input  busy, acesso_ok, acesso_negado, slot_match, bloqueado, tentativas
  );
endinterface

// File: rtl/controle_verificacao.sv
// Runs a latched keypad entry through the shared verifier against each active
// slot, lowest first, then issues grant/deny and enforces a timed lockout.
module controle_verificacao #(
  parameter int NUM_SLOTS       = 4,
  parameter int MAX_TENTATIVAS  = 3,
  parameter int BLOQUEIO_CICLOS = 1000,
  parameter int VS_TIMEOUT      = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  controle_verificacao_if.slave  bus
);
  import controle_verificacao_pkg::*;

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int TMO_W = $clog2(VS_TIMEOUT + 1);
  localparam int BLK_W = $clog2(BLOQUEIO_CICLOS + 1);

  typedef enum logic [2:0] {
    IDLE, LIMPA, DISPARA, AGUARDA, PROXIMO, CONCEDIDO, NEGADO, BLOQUEIO
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } busca_t;

  // Lowest set bit of mask at or above inicio.
  function automatic busca_t busca(input logic [NUM_SLOTS-1:0] mask, input int inicio);
    busca_t res;
    res = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (i >= inicio && mask[i]) begin
        res.found = 1'b1;
        res.idx   = IDX_W'(i);
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] slot_idx_q, slot_idx_d;
  senhaPac_t        senha_teste_q, senha_teste_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [3:0]       tent_q, tent_d;
  logic [IDX_W-1:0] match_q, match_d;
  logic             vs_clr_q, vs_clr_d;
  logic             vs_valid_q, vs_valid_d;
  logic             busy_q, busy_d;
  logic             ok_q, ok_d;
  logic             neg_q, neg_d;
  logic             bloq_q, bloq_d;
  busca_t           achado;

  always_comb begin
    state_d       = state_q;
    slot_idx_d    = slot_idx_q;
    senha_teste_d = senha_teste_q;
    tmo_d         = tmo_q;
    blk_d         = blk_q;
    tent_d        = tent_q;
    match_d       = match_q;
    achado        = '0;

    case (state_q)
      IDLE: begin
        if (bus.senha_valid && !bloq_q) begin
          senha_teste_d = bus.senha_in;
          achado        = busca(bus.slot_ativo, 0);
          slot_idx_d    = achado.idx;
          state_d       = achado.found ? LIMPA : NEGADO;
        end
      end
      LIMPA:   state_d = DISPARA;
      DISPARA: begin
        tmo_d   = '0;
        state_d = AGUARDA;
      end
      AGUARDA: begin
        // A late answer landing on the timeout cycle still counts.
        if (bus.vs_done) begin
          state_d = bus.vs_senha_ok ? CONCEDIDO : PROXIMO;
        end else if (tmo_q == TMO_W'(VS_TIMEOUT - 1)) begin
          state_d = PROXIMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      PROXIMO: begin
        achado = busca(bus.slot_ativo, int'(slot_idx_q) + 1);
        if (achado.found) begin
          slot_idx_d = achado.idx;
          state_d    = LIMPA;
        end else begin
          state_d    = NEGADO;
        end
      end
      CONCEDIDO: state_d = IDLE;
      NEGADO: begin
        if (tent_q == 4'(MAX_TENTATIVAS)) begin
          blk_d   = BLK_W'(BLOQUEIO_CICLOS - 1);
          state_d = BLOQUEIO;
        end else begin
          state_d = IDLE;
        end
      end
      BLOQUEIO: begin
        if (blk_q == '0) begin
          tent_d  = '0;
          state_d = IDLE;
        end else begin
          blk_d   = blk_q - BLK_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Counters update on entry so they are visible alongside the pulse.
    if (state_d == CONCEDIDO && state_q != CONCEDIDO) begin
      match_d = slot_idx_q;
      tent_d  = '0;
    end
    if (state_d == NEGADO && state_q != NEGADO) begin
      tent_d = sat_inc(tent_q);
    end

    vs_clr_d   = (state_d == LIMPA);
    vs_valid_d = (state_d == DISPARA);
    busy_d     = (state_d != IDLE);
    ok_d       = (state_d == CONCEDIDO);
    neg_d      = (state_d == NEGADO);
    bloq_d     = (state_d == BLOQUEIO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      slot_idx_q    <= '0;
      senha_teste_q <= '0;
      tmo_q         <= '0;
      blk_q         <= '0;
      tent_q        <= '0;
      match_q       <= '0;
      vs_clr_q      <= 1'b0;
      vs_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      ok_q          <= 1'b0;
      neg_q         <= 1'b0;
      bloq_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_idx_q    <= slot_idx_d;
      senha_teste_q <= senha_teste_d;
      tmo_q         <= tmo_d;
      blk_q         <= blk_d;
      tent_q        <= tent_d;
      match_q       <= match_d;
      vs_clr_q      <= vs_clr_d;
      vs_valid_q    <= vs_valid_d;
      busy_q        <= busy_d;
      ok_q          <= ok_d;
      neg_q         <= neg_d;
      bloq_q        <= bloq_d;
    end
  end

  assign bus.vs_clr         = vs_clr_q;
  assign bus.vs_valid_in    = vs_valid_q;
  assign bus.vs_senha_teste = senha_teste_q;
  assign bus.vs_senha_real  = bus.senhas_cad[slot_idx_q];
  assign bus.busy           = busy_q;
  assign bus.acesso_ok      = ok_q;
  assign bus.acesso_negado  = neg_q;
  assign bus.slot_match     = match_q;
  assign bus.bloqueado      = bloq_q;
  assign bus.tentativas     = tent_q;

endmodule

// File: tb/tb_controle_verificacao.sv
// Directed bench for controle_verificacao with a behavioural verifier that
// answers (teste == real) a programmable number of cycles after each launch.
module tb_controle_verificacao;
  import controle_verificacao_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  controle_verificacao_if #(.NUM_SLOTS(4)) bus ();

  controle_verificacao #(
    .NUM_SLOTS(4), .MAX_TENTATIVAS(3), .BLOQUEIO_CICLOS(1000), .VS_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int vlat    = 1;
  bit never_done = 1'b0;

  typedef struct {
    logic [3:0] act;
    senhaPac_t  entry;
    int vlat;
    bit never;
    int inj;
    int e_clr, e_vld, e_ok, e_neg, e_match, e_tent_p, e_tent_end, e_mask, e_blk, e_pulse_k;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // Verifier model: done lands vlat cycles after vs_valid_in was seen.
  initial begin
    bus.vs_done     = 1'b0;
    bus.vs_senha_ok = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.vs_valid_in && !never_done) begin
        repeat (vlat) @(posedge clk);
        #1;
        bus.vs_done     = 1'b1;
        bus.vs_senha_ok = (bus.vs_senha_teste == bus.vs_senha_real);
        @(posedge clk); #1;
        bus.vs_done     = 1'b0;
        bus.vs_senha_ok = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic run_vec(input vec_t v, input string tag);
    int k, n_clr, n_vld, n_ok, n_neg, blk, pulse_k, tent_p;
    logic [3:0] mask;
    bit fim;
    n_clr = 0; n_vld = 0; n_ok = 0; n_neg = 0; blk = 0;
    pulse_k = -1; tent_p = -1; mask = '0; fim = 1'b0; k = 0;
    vlat = v.vlat;
    never_done = v.never;
    @(negedge clk);
    bus.slot_ativo  = v.act;
    bus.senha_in    = v.entry;
    bus.senha_valid = 1'b1;
    while (!fim && k < 1500) begin
      @(negedge clk);
      bus.senha_valid = (k == v.inj);
      if (bus.vs_clr) n_clr++;
      if (bus.vs_valid_in) begin
        n_vld++;
        for (int i = 0; i < 4; i++)
          if (bus.vs_senha_real == bus.senhas_cad[i]) mask[i] = 1'b1;
      end
      if (bus.acesso_ok) begin
        n_ok++; pulse_k = k; tent_p = int'(bus.tentativas);
      end
      if (bus.acesso_negado) begin
        n_neg++; pulse_k = k; tent_p = int'(bus.tentativas);
      end
      if (bus.bloqueado) blk++;
      if (!bus.busy) fim = 1'b1;
      k++;
    end
    chk({tag, " end_reached"}, fim, 1);
    chk({tag, " vs_clr_count"}, n_clr, v.e_clr);
    chk({tag, " vs_valid_count"}, n_vld, v.e_vld);
    chk({tag, " launched_slots"}, mask, v.e_mask);
    chk({tag, " acesso_ok_count"}, n_ok, v.e_ok);
    chk({tag, " acesso_negado_count"}, n_neg, v.e_neg);
    chk({tag, " pulse_cycle"}, pulse_k, v.e_pulse_k);
    chk({tag, " tentativas_at_pulse"}, tent_p, v.e_tent_p);
    chk({tag, " bloqueado_cycles"}, blk, v.e_blk);
    chk({tag, " slot_match"}, bus.slot_match, v.e_match);
    chk({tag, " tentativas_end"}, bus.tentativas, v.e_tent_end);
  endtask

  initial begin
    //              act      entry     L  nv inj  clr vld ok neg mt tp te mask     blk  pk
    tbl[0] = '{4'b0001, 16'h1111, 5, 1'b0, -1,  1, 1, 1, 0, 0, 0, 0, 4'b0001, 0,    7};
    tbl[1] = '{4'b1010, 16'h4444, 4, 1'b0,  3,  2, 2, 1, 0, 3, 0, 0, 4'b1010, 0,   13};
    tbl[2] = '{4'b1111, 16'h3333, 2, 1'b0, -1,  3, 3, 1, 0, 2, 0, 0, 4'b0111, 0,   14};
    tbl[3] = '{4'b0000, 16'h1111, 2, 1'b0, -1,  0, 0, 0, 1, 2, 1, 1, 4'b0000, 0,    0};
    tbl[4] = '{4'b0001, 16'h9999, 5, 1'b1, 30,  1, 1, 0, 1, 2, 2, 2, 4'b0001, 0,   67};
    tbl[5] = '{4'b0100, 16'h9999, 3, 1'b0, 500, 1, 1, 0, 1, 2, 3, 0, 4'b0100, 1000, 6};
    tbl[6] = '{4'b1000, 16'h4444, 1, 1'b0, -1,  1, 1, 1, 0, 3, 0, 0, 4'b1000, 0,    3};
    tbl[7] = '{4'b0010, 16'h9999, 2, 1'b0, -1,  1, 1, 0, 1, 3, 1, 1, 4'b0010, 0,    5};

    rst = 1'b1;
    bus.senha_valid = 1'b0;
    bus.senha_in    = '0;
    bus.slot_ativo  = '0;
    for (int i = 0; i < 4; i++) bus.senhas_cad[i] = 16'(16'h1111 * (i + 1));
    repeat (3) @(negedge clk);
    chk("reset busy", bus.busy, 0);
    chk("reset pulses", {bus.vs_clr, bus.vs_valid_in, bus.acesso_ok, bus.acesso_negado}, 0);
    chk("reset bloqueado", bus.bloqueado, 0);
    chk("reset tentativas", bus.tentativas, 0);
    chk("reset slot_match", bus.slot_match, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 8; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

    // Entry discarded during lockout must not start a check afterwards.
    repeat (3) @(negedge clk);
    chk("idle_after_vectors busy", bus.busy, 0);

    // Async reset while waiting on a silent verifier.
    never_done = 1'b1;
    bus.slot_ativo = 4'b0001;
    @(negedge clk);
    bus.senha_in = 16'h1111;
    bus.senha_valid = 1'b1;
    @(negedge clk);
    bus.senha_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("midcheck busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid busy", bus.busy, 0);
    chk("rst_mid tentativas", bus.tentativas, 0);
    chk("rst_mid slot_match", bus.slot_match, 0);
    chk("rst_mid vs_senha_teste", bus.vs_senha_teste, 0);
    chk("rst_mid pulses", {bus.vs_clr, bus.vs_valid_in, bus.acesso_ok, bus.acesso_negado, bus.bloqueado}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_vec('{4'b0001, 16'h1111, 5, 1'b0, -1, 1, 1, 1, 0, 0, 0, 0, 4'b0001, 0, 7}, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
